// File: rtl/led_pattern_gen.sv
// Multi-pattern LED driver: a shared prescaler steps one of four runtime-selected
// patterns (binary count, bouncing scan, PWM breathe, blink-all) onto CHANNELS registered outputs.
module led_pattern_gen #(
    parameter int CHANNELS = 8,
    parameter int DIV      = 22,
    parameter int PWM_BITS = 8
) (
    input  logic                CLK,
    input  logic                RSTN,
    input  logic                EN,
    input  logic [1:0]          MODE,
    output logic [CHANNELS-1:0] OUT,
    output logic                TICK
);
    localparam int POSW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [1:0] M_COUNT   = 2'd0;
    localparam logic [1:0] M_SCAN    = 2'd1;
    localparam logic [1:0] M_BREATHE = 2'd2;

    localparam logic [POSW-1:0] POS_LAST = POSW'(CHANNELS - 1);
    localparam logic [POSW-1:0] POS_TURN = POSW'((CHANNELS > 1) ? CHANNELS - 2 : 0);
    localparam logic [POSW-1:0] POS_ONE  = POSW'(1);

    logic [DIV-1:0]      presc, presc_d;
    logic [1:0]          mode_q, mode_d;
    logic [CHANNELS-1:0] step, step_d;
    logic [POSW-1:0]     pos, pos_d;
    logic                dir_down, dir_down_d;
    logic [PWM_BITS-1:0] duty, duty_d;
    logic                ramp_down, ramp_down_d;
    logic [PWM_BITS-1:0] pwm_cnt, pwm_d;
    logic                blink, blink_d;
    logic                tick_i;
    logic [CHANNELS-1:0] pattern, out_d;

    // A pending mode change suppresses the step so the new pattern starts cleanly.
    assign tick_i = EN && (presc == '1) && (MODE == mode_q);

    always_comb begin
        pattern = '0;
        case (mode_q)
            M_COUNT:   pattern = step;
            M_SCAN:    pattern[pos] = 1'b1;
            M_BREATHE: pattern = {CHANNELS{pwm_cnt < duty}};
            default:   pattern = {CHANNELS{blink}};
        endcase
    end

    always_comb begin
        presc_d     = presc;
        mode_d      = mode_q;
        step_d      = step;
        pos_d       = pos;
        dir_down_d  = dir_down;
        duty_d      = duty;
        ramp_down_d = ramp_down;
        pwm_d       = pwm_cnt;
        blink_d     = blink;
        out_d       = OUT;
        if (EN) begin
            out_d = pattern;
            if (MODE != mode_q) begin
                mode_d      = MODE;
                presc_d     = '0;
                step_d      = '0;
                pos_d       = '0;
                dir_down_d  = 1'b0;
                duty_d      = '0;
                ramp_down_d = 1'b0;
                pwm_d       = '0;
                blink_d     = 1'b0;
            end else begin
                presc_d = presc + 1'b1;
                pwm_d   = pwm_cnt + 1'b1;
            end
            if (tick_i) begin
                case (mode_q)
                    M_COUNT: step_d = step + 1'b1;
                    M_SCAN: begin
                        // End positions turn around in place so each end is shown for one tick.
                        if (CHANNELS > 1) begin
                            if (!dir_down) begin
                                if (pos == POS_LAST) begin
                                    dir_down_d = 1'b1;
                                    pos_d      = POS_TURN;
                                end else begin
                                    pos_d = pos + 1'b1;
                                end
                            end else begin
                                if (pos == '0) begin
                                    dir_down_d = 1'b0;
                                    pos_d      = POS_ONE;
                                end else begin
                                    pos_d = pos - 1'b1;
                                end
                            end
                        end
                    end
                    M_BREATHE: begin
                        if (!ramp_down) begin
                            if (duty == '1) begin
                                ramp_down_d = 1'b1;
                                duty_d      = duty - 1'b1;
                            end else begin
                                duty_d = duty + 1'b1;
                            end
                        end else begin
                            if (duty == '0) begin
                                ramp_down_d = 1'b0;
                                duty_d      = duty + 1'b1;
                            end else begin
                                duty_d = duty - 1'b1;
                            end
                        end
                    end
                    default: blink_d = ~blink;
                endcase
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            presc     <= '0;
            mode_q    <= M_COUNT;
            step      <= '0;
            pos       <= '0;
            dir_down  <= 1'b0;
            duty      <= '0;
            ramp_down <= 1'b0;
            pwm_cnt   <= '0;
            blink     <= 1'b0;
            OUT       <= '0;
            TICK      <= 1'b0;
        end else begin
            presc     <= presc_d;
            mode_q    <= mode_d;
            step      <= step_d;
            pos       <= pos_d;
            dir_down  <= dir_down_d;
            duty      <= duty_d;
            ramp_down <= ramp_down_d;
            pwm_cnt   <= pwm_d;
            blink     <= blink_d;
            OUT       <= out_d;
            TICK      <= tick_i;
        end
    end
endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: two instances (4 channels and 1 channel) checked each cycle
// against an arithmetic model that derives every output from the count of enabled cycles.
module tb_led_pattern_gen;
    localparam int CH       = 4;
    localparam int DIVW     = 2;
    localparam int PWMW     = 3;
    localparam int STEP_CYC = 1 << DIVW;
    localparam int PWM_PER  = 1 << PWMW;
    localparam int DMAX     = PWM_PER - 1;

    logic          CLK = 1'b0;
    logic          RSTN;
    logic          EN;
    logic [1:0]    MODE;
    logic [CH-1:0] out4;
    logic          tick4;
    logic [0:0]    out1;
    logic          tick1;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Model: mode in force, enabled cycles since that mode started, expected outputs.
    int            m_mode;
    int            m_n;
    logic [CH-1:0] m_out4;
    logic          m_out1;
    logic          m_tick;

    always #5 CLK = ~CLK;

    led_pattern_gen #(.CHANNELS(CH), .DIV(DIVW), .PWM_BITS(PWMW)) u_dut (
        .CLK(CLK), .RSTN(RSTN), .EN(EN), .MODE(MODE), .OUT(out4), .TICK(tick4)
    );

    led_pattern_gen #(.CHANNELS(1), .DIV(DIVW), .PWM_BITS(PWMW)) u_dut1 (
        .CLK(CLK), .RSTN(RSTN), .EN(EN), .MODE(MODE), .OUT(out1), .TICK(tick1)
    );

    // Pattern shown for a mode after n enabled cycles: k ticks have elapsed.
    function automatic logic [CH-1:0] ref_out(int ch, int mode, int n);
        int k, pw, r, per, duty, mask;
        logic [CH-1:0] res;
        k    = n / STEP_CYC;
        pw   = n % PWM_PER;
        mask = (1 << ch) - 1;
        res  = '0;
        case (mode)
            0: res = CH'(k & mask);
            1: begin
                if (ch == 1) res = CH'(1);
                else begin
                    per = 2 * (ch - 1);
                    r   = k % per;
                    res = CH'(1 << ((r < ch) ? r : per - r));
                end
            end
            2: begin
                r    = k % (2 * DMAX);
                duty = (r <= DMAX) ? r : 2 * DMAX - r;
                res  = (pw < duty) ? CH'(mask) : '0;
            end
            default: res = (k % 2 == 1) ? CH'(mask) : '0;
        endcase
        return res;
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_n    = 0;
        m_out4 = '0;
        m_out1 = 1'b0;
        m_tick = 1'b0;
    endtask

    // Advance the model by one edge using the current inputs, then wait for that edge.
    task automatic clk_edge();
        logic [CH-1:0] o1;
        if (EN) begin
            m_out4 = ref_out(CH, m_mode, m_n);
            o1     = ref_out(1, m_mode, m_n);
            m_out1 = o1[0];
            if (int'(MODE) != m_mode) begin
                m_mode = int'(MODE);
                m_n    = 0;
                m_tick = 1'b0;
            end else begin
                m_n++;
                m_tick = (m_n % STEP_CYC == 0);
            end
        end else begin
            m_tick = 1'b0;
        end
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        RSTN = 1'b0;
        EN   = 1'b0;
        MODE = 2'd0;
        repeat (2) @(posedge CLK);
        #1;
        n_cmp++;
        if (out4 !== 4'b0000 || tick4 !== 1'b0 || out1 !== 1'b0 || tick1 !== 1'b0) begin
            n_bad++;
            $display("FAIL reset got out=%b tick=%b out1=%b tick1=%b exp 0000 0 0 0", out4, tick4, out1, tick1);
        end
        RSTN = 1'b1;
        model_reset();
    endtask

    task automatic test_count();
        EN   = 1'b1;
        MODE = 2'd0;
        for (int i = 0; i < 70; i++) begin
            clk_edge();
            n_cmp++;
            if (out4 !== m_out4 || tick4 !== m_tick || out1 !== m_out1 || tick1 !== m_tick) begin
                n_bad++;
                $display("FAIL count cyc=%0d got out=%b tick=%b out1=%b exp out=%b tick=%b out1=%b",
                         cyc, out4, tick4, out1, m_out4, m_tick, m_out1);
            end
        end
    endtask

    task automatic test_scan();
        EN   = 1'b1;
        MODE = 2'd1;
        for (int i = 0; i < 50; i++) begin
            clk_edge();
            n_cmp++;
            if (out4 !== m_out4 || tick4 !== m_tick || out1 !== m_out1 || tick1 !== m_tick) begin
                n_bad++;
                $display("FAIL scan cyc=%0d got out=%b tick=%b out1=%b exp out=%b tick=%b out1=%b",
                         cyc, out4, tick4, out1, m_out4, m_tick, m_out1);
            end
        end
    endtask

    task automatic test_breathe();
        EN   = 1'b1;
        MODE = 2'd2;
        for (int i = 0; i < 130; i++) begin
            clk_edge();
            n_cmp++;
            if (out4 !== m_out4 || tick4 !== m_tick || out1 !== m_out1 || tick1 !== m_tick) begin
                n_bad++;
                $display("FAIL breathe cyc=%0d got out=%b tick=%b out1=%b exp out=%b tick=%b out1=%b",
                         cyc, out4, tick4, out1, m_out4, m_tick, m_out1);
            end
        end
    endtask

    task automatic test_blink_pause();
        logic [CH-1:0] held;
        EN   = 1'b1;
        MODE = 2'd3;
        for (int i = 0; i < 58; i++) begin
            if (i == 18) held = out4;
            EN = (i >= 18 && i < 28) ? 1'b0 : 1'b1;
            clk_edge();
            n_cmp++;
            if (out4 !== m_out4 || tick4 !== m_tick || out1 !== m_out1) begin
                n_bad++;
                $display("FAIL blink cyc=%0d got out=%b tick=%b out1=%b exp out=%b tick=%b out1=%b",
                         cyc, out4, tick4, out1, m_out4, m_tick, m_out1);
            end
            if (i >= 18 && i < 28) begin
                n_cmp++;
                if (out4 !== held || tick4 !== 1'b0) begin
                    n_bad++;
                    $display("FAIL blink_freeze cyc=%0d got out=%b tick=%b exp out=%b tick=0",
                             cyc, out4, tick4, held);
                end
            end
        end
    endtask

    task automatic test_mode_switch();
        int cnt;
        EN   = 1'b1;
        MODE = 2'd0;
        clk_edge();
        while (m_n < 9 * STEP_CYC + 2) begin
            clk_edge();
            n_cmp++;
            if (out4 !== m_out4 || tick4 !== m_tick) begin
                n_bad++;
                $display("FAIL pre_switch cyc=%0d got out=%b tick=%b exp out=%b tick=%b",
                         cyc, out4, tick4, m_out4, m_tick);
            end
        end
        n_cmp++;
        if (out4 !== 4'd9) begin
            n_bad++;
            $display("FAIL switch_step got out=%b exp 1001", out4);
        end
        MODE = 2'd1;
        clk_edge();
        n_cmp++;
        if (tick4 !== 1'b0) begin
            n_bad++;
            $display("FAIL switch_no_tick got tick=%b exp 0", tick4);
        end
        cnt = 0;
        do begin
            clk_edge();
            cnt++;
        end while (tick4 !== 1'b1 && cnt < 20);
        n_cmp++;
        if (cnt != 4 || out4 !== 4'b0001) begin
            n_bad++;
            $display("FAIL switch_first_tick got cycles=%0d out=%b exp cycles=4 out=0001", cnt, out4);
        end
        clk_edge();
        n_cmp++;
        if (out4 !== 4'b0010) begin
            n_bad++;
            $display("FAIL switch_first_step got out=%b exp 0010", out4);
        end
    endtask

    task automatic test_en_mode_ignore();
        logic [CH-1:0] held;
        held = out4;
        EN   = 1'b0;
        MODE = 2'd3;
        for (int i = 0; i < 6; i++) begin
            clk_edge();
            n_cmp++;
            if (out4 !== held || tick4 !== 1'b0 || out4 !== m_out4) begin
                n_bad++;
                $display("FAIL en0_mode cyc=%0d got out=%b tick=%b exp out=%b tick=0", cyc, out4, tick4, held);
            end
        end
        EN = 1'b1;
        for (int i = 0; i < 14; i++) begin
            clk_edge();
            n_cmp++;
            if (out4 !== m_out4 || tick4 !== m_tick || out1 !== m_out1) begin
                n_bad++;
                $display("FAIL en1_mode cyc=%0d got out=%b tick=%b out1=%b exp out=%b tick=%b out1=%b",
                         cyc, out4, tick4, out1, m_out4, m_tick, m_out1);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            EN = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 39) == 0) MODE = 2'($urandom_range(0, 3));
            clk_edge();
            n_cmp++;
            if (out4 !== m_out4 || tick4 !== m_tick || out1 !== m_out1 || tick1 !== m_tick) begin
                n_bad++;
                $display("FAIL random cyc=%0d en=%b mode=%0d got out=%b tick=%b out1=%b exp out=%b tick=%b out1=%b",
                         cyc, EN, MODE, out4, tick4, out1, m_out4, m_tick, m_out1);
            end
        end
    endtask

    task automatic test_async_reset();
        EN   = 1'b1;
        MODE = 2'd2;
        for (int i = 0; i < 45; i++) clk_edge();
        #3;
        RSTN = 1'b0;
        #1;
        n_cmp++;
        if (out4 !== 4'b0000 || tick4 !== 1'b0 || out1 !== 1'b0 || tick1 !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset got out=%b tick=%b out1=%b tick1=%b exp 0000 0 0 0", out4, tick4, out1, tick1);
        end
        repeat (2) @(posedge CLK);
        #1;
        RSTN = 1'b1;
        model_reset();
        MODE = 2'd0;
        for (int i = 0; i < 30; i++) begin
            clk_edge();
            n_cmp++;
            if (out4 !== m_out4 || tick4 !== m_tick || out1 !== m_out1) begin
                n_bad++;
                $display("FAIL post_reset cyc=%0d got out=%b tick=%b out1=%b exp out=%b tick=%b out1=%b",
                         cyc, out4, tick4, out1, m_out4, m_tick, m_out1);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_count();
        test_scan();
        test_breathe();
        test_blink_pause();
        test_mode_switch();
        test_en_mode_ignore();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
